// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI initiator: command opcodes, frame geometry and
// the controller state encoding.
// Optional feature macro used by the top level: SPI_MASTER_AUTO_READ_EN.
// -----------------------------------------------------------------------------
package spi_pkg;

    localparam logic [1:0] OP_WADDR = 2'b00;
    localparam logic [1:0] OP_WDATA = 2'b01;
    localparam logic [1:0] OP_RADDR = 2'b10;
    localparam logic [1:0] OP_RDATA = 2'b11;

    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_TX   = 3'd1,
        ST_TURN = 3'd2,
        ST_RX   = 3'd3,
        ST_GAP  = 3'd4
    } state_t;

endpackage

// File: rtl/spi_sclk_gen.sv
// -----------------------------------------------------------------------------
// spi_sclk_gen
// Registered SCLK divider. While enabled, sclk spends HALF_DIV system clocks low
// and HALF_DIV high, starting low. rise_tick/fall_tick are high in the clk cycle
// whose closing edge moves sclk 0->1 / 1->0. Disabling forces sclk low and
// restarts the divider so every frame begins with a full low half-period.
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   en         divider run enable (frame active)
//   sclk       SPI clock, idles low
//   rise_tick  strobe: sclk rises at the next edge
//   fall_tick  strobe: sclk falls at the next edge
// -----------------------------------------------------------------------------
module spi_sclk_gen #(
    parameter int HALF_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int DW = $clog2(HALF_DIV) + 1;

    logic [DW-1:0] div_cnt;
    logic          tc;

    assign tc        = en && (div_cnt == DW'(HALF_DIV - 1));
    assign rise_tick = tc && !sclk;
    assign fall_tick = tc && sclk;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (tc) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// -----------------------------------------------------------------------------
// spi_master_ctrl
// SPI initiator (mode 0) for the command/response protocol of the SPI-slave
// memory subsystem. One host command = 2-bit op + 8-bit payload, sent MSB first
// in a single ss_n-low frame. Read-data (op 11) frames add one turnaround SCLK
// period and then clock 8 bits in from miso, returned on rsp_valid/rsp_data.
// Optional feature: `define SPI_MASTER_AUTO_READ_EN makes an accepted op 10
// automatically follow its frame (after the inter-frame gap) with an op-11 frame;
// only the second frame reports done/rsp_valid.
// Host handshake: a command is taken on the clk edge where req_valid and
// req_ready are both high; req_valid while req_ready is low is not queued.
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   req_valid/req_ready  command handshake
//   req_op, req_data     command opcode and payload
//   done                 one-cycle pulse at the end of a frame
//   rsp_valid, rsp_data  one-cycle read-data pulse; rsp_data holds afterwards
//   sclk, ss_n, mosi     SPI outputs
//   miso                 SPI input
//   dbg_state            current controller state (state_t encoding)
// -----------------------------------------------------------------------------
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int HALF_DIV = 2,
    parameter int GAP_CYC  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [7:0] req_data,
    output logic       done,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       sclk,
    output logic       ss_n,
    output logic       mosi,
    input  logic       miso,
    output logic [2:0] dbg_state
);

    localparam int GW = $clog2(GAP_CYC) + 1;

    state_t                state, state_d;
    logic [FRAME_BITS-1:0] shift_q;
    logic [1:0]            op_q;
    logic [3:0]            bit_cnt;
    logic [DATA_BITS-1:0]  rx_q;
    logic [GW-1:0]         gap_cnt;
    logic                  auto_pend;
    logic                  sclk_en, rise_tick, fall_tick;
    logic                  hs, tx_last, rx_last, gap_last;

    assign req_ready = (state == ST_IDLE);
    assign hs        = req_valid && req_ready;
    assign dbg_state = state;
    assign sclk_en   = (state == ST_TX) || (state == ST_TURN) || (state == ST_RX);
    // The shifter fills with zeros, so mosi reads 0 whenever no command bit is out.
    assign mosi      = shift_q[FRAME_BITS-1];
    assign tx_last   = fall_tick && (bit_cnt == 4'(FRAME_BITS - 1));
    assign rx_last   = fall_tick && (bit_cnt == 4'(DATA_BITS - 1));
    assign gap_last  = (gap_cnt == GW'(GAP_CYC - 1));

    spi_sclk_gen #(.HALF_DIV(HALF_DIV)) u_sclk_gen (
        .clk       (clk),
        .rst       (rst),
        .en        (sclk_en),
        .sclk      (sclk),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: if (hs)        state_d = ST_TX;
            ST_TX:   if (tx_last)   state_d = (op_q == OP_RDATA) ? ST_TURN : ST_GAP;
            ST_TURN: if (fall_tick) state_d = ST_RX;
            ST_RX:   if (rx_last)   state_d = ST_GAP;
            // A pending automatic read re-enters TX straight from the gap.
            ST_GAP:  if (gap_last)  state_d = auto_pend ? ST_TX : ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q   <= '0;
            op_q      <= OP_WADDR;
            bit_cnt   <= '0;
            rx_q      <= '0;
            gap_cnt   <= '0;
            auto_pend <= 1'b0;
            ss_n      <= 1'b1;
            done      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            done      <= 1'b0;
            rsp_valid <= 1'b0;
            gap_cnt   <= (state == ST_GAP) ? gap_cnt + 1'b1 : '0;
            case (state)
                ST_IDLE: begin
                    if (hs) begin
                        shift_q <= {req_op, req_data};
                        op_q    <= req_op;
                        bit_cnt <= '0;
                        ss_n    <= 1'b0;
`ifdef SPI_MASTER_AUTO_READ_EN
                        auto_pend <= (req_op == OP_RADDR);
`else
                        auto_pend <= 1'b0;
`endif
                    end
                end
                ST_TX: begin
                    // Next bit is presented on the same edge sclk falls.
                    if (fall_tick) begin
                        shift_q <= {shift_q[FRAME_BITS-2:0], 1'b0};
                        if (tx_last) begin
                            bit_cnt <= '0;
                            if (op_q != OP_RDATA) begin
                                ss_n <= 1'b1;
                                // The first frame of an automatic read stays silent.
                                done <= !auto_pend;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                ST_RX: begin
                    if (rise_tick) rx_q <= {rx_q[DATA_BITS-2:0], miso};
                    if (fall_tick) begin
                        if (rx_last) begin
                            bit_cnt   <= '0;
                            ss_n      <= 1'b1;
                            done      <= 1'b1;
                            rsp_valid <= 1'b1;
                            rsp_data  <= rx_q;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_last && auto_pend) begin
                        shift_q   <= {OP_RDATA, {DATA_BITS{1'b0}}};
                        op_q      <= OP_RDATA;
                        bit_cnt   <= '0;
                        ss_n      <= 1'b0;
                        auto_pend <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_master_ctrl
// Bench for spi_master_ctrl (HALF_DIV=2, GAP_CYC=4). A negedge monitor acts as
// the SPI slave + memory (decodes frames from the pins, serves read data on
// miso) and as the host-side reference model (command queue, memory/address
// model, handshake-to-done latency). Honors SPI_MASTER_AUTO_READ_EN.
// -----------------------------------------------------------------------------
module tb_spi_master_ctrl;

    localparam int HALF_DIV = 2;
    localparam int GAP_CYC  = 4;

    logic       clk, rst, req_valid, req_ready, done, rsp_valid;
    logic [1:0] req_op;
    logic [7:0] req_data, rsp_data;
    logic       sclk, ss_n, mosi, miso;
    logic [2:0] dbg_state;

    spi_master_ctrl #(.HALF_DIV(HALF_DIV), .GAP_CYC(GAP_CYC)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_data  (req_data),
        .done      (done),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .sclk      (sclk),
        .ss_n      (ss_n),
        .mosi      (mosi),
        .miso      (miso),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int hs_count = 0;
    int sclk_edges = 0;
    int idle_bad = 0;
    int rises = 0;
    int gap_run = 100;
    logic prev_sclk = 1'b0;
    logic prev_ss = 1'b1;
    logic [9:0] cap = '0;
    logic tail_bad = 1'b0;
    logic [7:0] slv_mem [256];
    logic [7:0] slv_addr = '0;
    logic [7:0] slv_byte = '0;
    logic [7:0] ref_mem [256];
    logic [7:0] ref_addr = '0;
    logic [7:0] last_rd = '0;

    logic [1:0] pend_op_q[$];
    logic [7:0] pend_data_q[$];
    int         pend_cyc_q[$];
    logic [9:0] exp_q[$];
    int         exp_rises_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int exp_lat(input logic [1:0] op);
        if (op == 2'b11) return 1 + 38 * HALF_DIV;
`ifdef SPI_MASTER_AUTO_READ_EN
        if (op == 2'b10) return 1 + 58 * HALF_DIV + GAP_CYC;
`endif
        return 1 + 20 * HALF_DIV;
    endfunction

    // ---------------- slave model + reference model ----------------
    always @(negedge clk) begin
        logic [1:0] op;
        logic [7:0] d;
        int         c;
        logic       rd_exp;
        cyc++;
        if (sclk && !prev_sclk) sclk_edges++;
        if (ss_n && (sclk || mosi)) idle_bad++;
        if (rst) begin
            pend_op_q.delete(); pend_data_q.delete(); pend_cyc_q.delete();
            exp_q.delete(); exp_rises_q.delete();
            rises = 0; cap = '0; tail_bad = 1'b0; gap_run = 100; last_rd = '0;
        end else begin
            if (req_valid && req_ready) begin
                hs_count++;
                pend_op_q.push_back(req_op);
                pend_data_q.push_back(req_data);
                pend_cyc_q.push_back(cyc);
                exp_q.push_back({req_op, req_data});
                exp_rises_q.push_back(req_op == 2'b11 ? 19 : 10);
`ifdef SPI_MASTER_AUTO_READ_EN
                if (req_op == 2'b10) begin
                    exp_q.push_back(10'h300);
                    exp_rises_q.push_back(19);
                end
`endif
            end
            if (!ss_n && sclk && !prev_sclk) begin
                if (rises < 10) cap = {cap[8:0], mosi};
                else if (mosi) tail_bad = 1'b1;
                rises++;
                if (rises == 10) slv_byte = slv_mem[slv_addr];
            end
            if (ss_n && !prev_ss) begin
                if (exp_q.size() == 0) begin
                    check("frame_unexpected", exp_q.size(), 1);
                end else begin
                    check("frame_word", cap, exp_q.pop_front());
                    check("frame_rises", rises, exp_rises_q.pop_front());
                    check("frame_tail_mosi", tail_bad, 0);
                end
                case (cap[9:8])
                    2'b00, 2'b10: slv_addr = cap[7:0];
                    2'b01:        slv_mem[slv_addr] = cap[7:0];
                    default: ;
                endcase
                rises = 0; cap = '0; tail_bad = 1'b0;
            end
            if (!ss_n && prev_ss) check("gap_len", gap_run >= GAP_CYC, 1);
            if (done) begin
                if (pend_op_q.size() == 0) begin
                    check("done_unexpected", done, 0);
                end else begin
                    op = pend_op_q.pop_front();
                    d  = pend_data_q.pop_front();
                    c  = pend_cyc_q.pop_front();
                    check("done_latency", cyc - c, exp_lat(op));
                    rd_exp = 1'b0;
                    case (op)
                        2'b00: ref_addr = d;
                        2'b01: ref_mem[ref_addr] = d;
                        2'b10: begin
                            ref_addr = d;
`ifdef SPI_MASTER_AUTO_READ_EN
                            rd_exp = 1'b1;
`endif
                        end
                        default: rd_exp = 1'b1;
                    endcase
                    check("rsp_valid", rsp_valid, rd_exp);
                    if (rd_exp) last_rd = ref_mem[ref_addr];
                    check("rsp_data", rsp_data, last_rd);
                end
            end else if (rsp_valid) begin
                check("rsp_without_done", rsp_valid, 0);
            end
        end
        gap_run   = ss_n ? gap_run + 1 : 0;
        prev_sclk = sclk;
        prev_ss   = ss_n;
        if (!ss_n && rises >= 11 && rises < 19) miso = slv_byte[18 - rises];
        else                                    miso = 1'($urandom_range(0, 1));
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [7:0] d, input bit keep);
        int start, n;
        req_op = op; req_data = d; req_valid = 1'b1;
        start = hs_count; n = 0;
        while (hs_count == start && n < 500) begin @(posedge clk); n++; end
        if (hs_count == start) check("hs_timeout", hs_count, start + 1);
        #1;
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk); #1;
        while (!(req_ready && pend_op_q.size() == 0) && n < 1000) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 1000) check("idle_timeout", pend_op_q.size(), 0);
        @(posedge clk); #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int e0, h0, n;
        logic [1:0] op;
        logic [7:0] d;
        for (int i = 0; i < 256; i++) begin
            slv_mem[i] = 8'(i * 5 + 1);
            ref_mem[i] = 8'(i * 5 + 1);
        end
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_data = '0; miso = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk); #1;
        check("rst_ss_n", ss_n, 1);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_done", done, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_req_ready", req_ready, 1);
        @(posedge clk); #1;

        // Idle: no SCLK activity for 100 clocks.
        e0 = sclk_edges;
        idle(100);
        check("idle_sclk_edges", sclk_edges - e0, 0);
        check("idle_ss_n", ss_n, 1);

        // Directed: write-addr, write-data, read-addr, read-data.
        send_cmd(2'b00, 8'h5A, 0); wait_idle();
        send_cmd(2'b01, 8'hC3, 0); wait_idle();
        send_cmd(2'b10, 8'h5A, 0); wait_idle();
        send_cmd(2'b11, 8'h00, 0); wait_idle();
        check("read_back_c3", rsp_data, 8'hC3);

        // req_valid held high across back-to-back commands.
        h0 = hs_count;
        send_cmd(2'b00, 8'h11, 1);
        send_cmd(2'b01, 8'h22, 1);
        send_cmd(2'b11, 8'hFF, 1);
        send_cmd(2'b01, 8'h33, 0);
        wait_idle();
        check("held_hs_count", hs_count - h0, 4);

        // Reset in the middle of a TX frame.
        send_cmd(2'b01, 8'h77, 0);
        n = 0;
        while (rises < 4 && n < 200) begin @(posedge clk); n++; end
        check("mid_rst_reached_bit5", rises >= 4, 1);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk); #1;
        check("mid_rst_ss_n", ss_n, 1);
        check("mid_rst_sclk", sclk, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_req_ready", req_ready, 1);
        @(posedge clk); #1 rst = 1'b0;
        idle(60);
        send_cmd(2'b01, 8'h99, 0); wait_idle();
        send_cmd(2'b11, 8'h00, 0); wait_idle();
        check("post_rst_read", rsp_data, 8'h99);

        // Randomized commands over a small address window.
        for (int i = 0; i < 30; i++) begin
            op = 2'($urandom_range(0, 3));
            d  = (op == 2'b01) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7));
            idle($urandom_range(0, 6));
            send_cmd(op, d, 0);
        end
        wait_idle();
        idle(10);

        check("pending_left", pend_op_q.size(), 0);
        check("frames_left", exp_q.size(), 0);
        check("idle_lines", idle_bad, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- SPI initiator that drives the command/response protocol of the SPI-slave + memory subsystem.
- Accepts one 10-bit command per host request: 2-bit op + 8-bit payload.
- Serializes each command MSB-first on MOSI inside one SS_n-low frame.
- For read-data commands, receives 8 bits back on MISO and returns them to the host.
- Sits between the system-side host/bus logic and the off-block SPI pins.

Parameters:
- HALF_DIV, 2: system clocks per SCLK half-period. Legal range is 1..255.
- GAP_CYC, 4: system clocks SS_n is held high between frames. Minimum 1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  host command valid
- req_ready  out  1  high when the block can accept a command
- req_op  in  2  00 write-addr, 01 write-data, 10 read-addr, 11 read-data
- req_data  in  8  address or data payload; ignored for op 11
- done  out  1  one-cycle pulse when a frame fully completes
- rsp_valid  out  1  one-cycle pulse carrying read data
- rsp_data  out  8  read data; holds its value until the next read completes
- sclk  out  1  SPI clock, idles low (mode 0)
- ss_n  out  1  slave select, active-low
- mosi  out  1  serial data to slave
- miso  in  1  serial data from slave

Behaviour:
- Reset (rst=1 at clk edge) sets:
  - ss_n=1, sclk=0, mosi=0
  - done=0, rsp_valid=0, rsp_data=0
  - state=IDLE, so req_ready=1
- Reset mid-frame abandons the frame immediately: no done, no rsp_valid.
- States: IDLE, TX, TURN, RX, GAP.
- IDLE:
  - req_ready = (state==IDLE), combinational.
  - Handshake when req_valid && req_ready.
  - On handshake: shift register <= {req_op, req_data}, op is latched, ss_n=0 and mosi=bit9 on the next cycle, go to TX.
- TX:
  - Each bit lasts 2*HALF_DIV clocks: sclk low HALF_DIV, then high HALF_DIV.
  - mosi changes only while sclk is low, in the same cycle sclk falls.
  - After the 10th bit's high phase ends: if op==11 go to TURN, else go to GAP.
- TURN:
  - One full SCLK period with mosi=0, giving the slave time to fetch memory.
  - Then go to RX.
- RX:
  - 8 SCLK periods.
  - miso is sampled in the clk cycle where sclk transitions 0->1, MSB first, into an 8-bit shift register.
  - Then go to GAP.
- GAP:
  - ss_n=1, sclk=0, mosi=0 for GAP_CYC clocks.
  - On GAP entry, for one cycle: done=1; if op==11, also rsp_valid=1 with rsp_data = received byte.
  - Return to IDLE after GAP_CYC clocks.
- Frame latency, handshake to done:
  - Ops 00/01/10: 1 + 20*HALF_DIV clocks.
  - Op 11: 1 + 38*HALF_DIV clocks.
  - Next handshake is possible GAP_CYC clocks after done.
- Width rules:
  - Divider counter is $clog2(HALF_DIV)+1 bits.
  - Bit counter is 4 bits and counts 0..9 in TX, 0..7 in RX.
  - No wrap beyond the terminal count.
- Busy: req_valid while req_ready=0 is ignored, not queued. The host must hold it.
- miso is ignored outside RX.
- sclk never glitches: it is registered and toggles only on divider terminal count.

Optional Feature:
- Macro: SPI_MASTER_AUTO_READ_EN.
- Defined:
  - An accepted op 10 runs the read-addr frame, then GAP_CYC idle clocks, then automatically an op-11 frame.
  - A single done pulse and rsp_valid are issued at the end of the second frame.
  - req_ready stays low across both frames.
  - Host op 11 is still legal.
- Undefined: op 10 is a plain 10-bit frame with a done pulse, and no auto read.

Decomposition:
- Package spi_pkg holds:
  - op localparams OP_WADDR=2'b00, OP_WDATA=2'b01, OP_RADDR=2'b10, OP_RDATA=2'b11
  - state enum encoding
  - FRAME_BITS=10, DATA_BITS=8
- One natural sub-module, spi_sclk_gen:
  - Contains the HALF_DIV divider.
  - Outputs sclk plus one-cycle rise_tick/fall_tick strobes.
  - Enabled only in TX/TURN/RX.

Test Plan:
- Reset then idle, HALF_DIV=2 -> ss_n=1, sclk=0, req_ready=1, no sclk edges for 100 clks.
- Write-addr op=00, data=0x5A -> bench slave captures 10'b00_0101_1010 over 10 rising sclk edges; done at 41 clks after handshake; no rsp_valid.
- Write-data op=01, data=0xC3, then read-addr 0x5A, then read-data with slave model returning 0xC3 -> rsp_valid pulse with rsp_data=0xC3 at 77 clks after the op-11 handshake.
- req_valid held high through a frame with back-to-back commands -> exactly one handshake per frame; ss_n high ≥ GAP_CYC=4 clks between frames.
- rst asserted at the 5th TX bit -> next clk: ss_n=1, sclk=0; no done/rsp_valid; next command frames correctly.
- SPI_MASTER_AUTO_READ_EN defined, op=10, data=0x5A, slave returns 0xC3 -> two frames (10'h25A, then 10'h300 + 8 read bits), a single done, rsp_data=0xC3.
